// File: rtl/hbmc_tx_ser_pkg.sv
// Shared definitions for the HyperBus transmit word sequencer: FSM states,
// command/address field positions and the CA word selector.
package hbmc_tx_ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_DATA,
        ST_DONE
    } tx_state_e;

    localparam int         CA_RW    = 47;
    localparam int         CA_AS    = 46;
    localparam int         CA_WORDS = 3;
    localparam logic [1:0] CA_LAST  = 2'(CA_WORDS - 1);

    // CA goes out most-significant word first.
    function automatic logic [15:0] ca_word(input logic [47:0] ca, input logic [1:0] idx);
        case (idx)
            2'd0:    return ca[47:32];
            2'd1:    return ca[31:16];
            default: return ca[15:0];
        endcase
    endfunction

endpackage

// File: rtl/hbmc_tx_ser_if.sv
// Write-data stream into the transmit sequencer: one 16-bit word plus byte
// enables per accepted beat.
interface hbmc_tx_ser_if;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic [1:0]  wr_strb;
    logic        wr_ready;

    modport master (output wr_valid, wr_data, wr_strb, input wr_ready);
    modport slave  (input wr_valid, wr_data, wr_strb, output wr_ready);
endinterface

// File: rtl/hbmc_tx_ser.sv
// HyperBus transmit sequencer: drives CA words, counts initial latency and
// streams masked write words, one DDR-split DQ/RWDS word per clk.
module hbmc_tx_ser
    import hbmc_tx_ser_pkg::*;
#(
    parameter int LAT_W = 6,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             tx_start,
    input  logic [47:0]      tx_ca,
    input  logic [LAT_W-1:0] tx_latency,
    input  logic [LEN_W-1:0] tx_len,
    hbmc_tx_ser_if.slave     wr,
    output logic [15:0]      dq_out,
    output logic             dq_oe,
    output logic [1:0]       rwds_out,
    output logic             rwds_oe,
    output logic             busy,
    output logic             done,
    output logic             underflow
);

    tx_state_e        state;
    logic [47:0]      ca_q;
    logic [1:0]       ca_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic [LEN_W-1:0] word_cnt;

    logic is_read, is_reg, ca_last, lat_last, slot_next;
    logic [15:0] slot_dq;
    logic [1:0]  slot_rwds;

    assign is_read  = ca_q[CA_RW];
    assign is_reg   = !ca_q[CA_RW] && ca_q[CA_AS];
    assign ca_last  = (ca_cnt == CA_LAST);
    assign lat_last = (lat_cnt == LAT_W'(1));

    // A data slot follows the current cycle; depends on state/counters only.
    always_comb begin
        slot_next = 1'b0;
        case (state)
            ST_CA:   slot_next = ca_last && !is_read && (is_reg || lat_cnt == '0);
            ST_LAT:  slot_next = lat_last;
            ST_DATA: slot_next = (word_cnt != '0);
            default: slot_next = 1'b0;
        endcase
    end

    assign wr.wr_ready = slot_next;

    // A starved memory slot is still emitted, fully masked, so the device
    // address keeps advancing; register writes have no mask at all.
    assign slot_dq   = wr.wr_valid ? wr.wr_data : 16'h0000;
    assign slot_rwds = is_reg ? 2'b00 : (wr.wr_valid ? ~wr.wr_strb : 2'b11);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= ST_IDLE;
            ca_q      <= '0;
            ca_cnt    <= '0;
            lat_cnt   <= '0;
            word_cnt  <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            rwds_out  <= '0;
            rwds_oe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            dq_out   <= '0;
            dq_oe    <= 1'b0;
            rwds_out <= '0;
            rwds_oe  <= 1'b0;
            done     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        state     <= ST_CA;
                        ca_q      <= tx_ca;
                        ca_cnt    <= '0;
                        lat_cnt   <= tx_latency;
                        word_cnt  <= tx_len;
                        busy      <= 1'b1;
                        underflow <= 1'b0;
                        dq_out    <= ca_word(tx_ca, 2'd0);
                        dq_oe     <= 1'b1;
                    end
                end
                ST_CA: begin
                    if (!ca_last) begin
                        ca_cnt <= ca_cnt + 2'd1;
                        dq_out <= ca_word(ca_q, ca_cnt + 2'd1);
                        dq_oe  <= 1'b1;
                    end else if (is_read) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (is_reg) begin
                        state    <= ST_DATA;
                        word_cnt <= '0;
                    end else if (lat_cnt == '0) begin
                        state <= ST_DATA;
                    end else begin
                        state <= ST_LAT;
                        if (lat_last) begin
                            rwds_oe  <= 1'b1;
                            rwds_out <= 2'b11;
                        end
                    end
                end
                ST_LAT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_last) begin
                        state <= ST_DATA;
                    end else if (lat_cnt == LAT_W'(2)) begin
                        // RWDS preamble in the final latency cycle
                        rwds_oe  <= 1'b1;
                        rwds_out <= 2'b11;
                    end
                end
                ST_DATA: begin
                    if (word_cnt != '0) begin
                        word_cnt <= word_cnt - LEN_W'(1);
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            if (slot_next) begin
                dq_out   <= slot_dq;
                dq_oe    <= 1'b1;
                rwds_out <= slot_rwds;
                rwds_oe  <= !is_reg;
                if (!wr.wr_valid) underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hbmc_tx_ser.sv
// Bench for hbmc_tx_ser: a table of transfers, each expanded into a per-cycle
// expected output stream that is queued as stimulus is driven.
module tb_hbmc_tx_ser;

    localparam int LAT_W = 6;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             arstn;
    logic             tx_start;
    logic [47:0]      tx_ca;
    logic [LAT_W-1:0] tx_latency;
    logic [LEN_W-1:0] tx_len;
    logic [15:0]      dq_out;
    logic             dq_oe;
    logic [1:0]       rwds_out;
    logic             rwds_oe;
    logic             busy;
    logic             done;
    logic             underflow;

    hbmc_tx_ser_if wr ();

    hbmc_tx_ser #(.LAT_W(LAT_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .arstn      (arstn),
        .tx_start   (tx_start),
        .tx_ca      (tx_ca),
        .tx_latency (tx_latency),
        .tx_len     (tx_len),
        .wr         (wr),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .rwds_out   (rwds_out),
        .rwds_oe    (rwds_oe),
        .busy       (busy),
        .done       (done),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr_ready;
        logic        dq_oe;
        logic [15:0] dq_out;
        logic        rwds_oe;
        logic [1:0]  rwds_out;
        logic        busy;
        logic        done;
        logic        underflow;
    } obs_t;

    // gap: starved slot (-1 none); nwords/done_t: expected slot count and
    // cycle of the done pulse, counted from the tx_start cycle (t=0).
    typedef struct {
        int          id;
        logic [47:0] ca;
        int          lat;
        int          len;
        logic [15:0] base;
        int          gap;
        int          strb_slot;
        logic [1:0]  strb_val;
        int          nwords;
        int          done_t;
    } vec_t;

    vec_t vecs [9];
    obs_t sb [$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] data_of(input vec_t v, input int j);
        return v.base ^ 16'(j * 257);
    endfunction

    function automatic logic [1:0] strb_of(input vec_t v, input int j);
        return (j == v.strb_slot) ? v.strb_val : 2'b11;
    endfunction

    function automatic obs_t expect_at(input vec_t v, input int t);
        obs_t e;
        bit   rd, rg;
        int   fs, j;
        rd = v.ca[47];
        rg = !v.ca[47] && v.ca[46];
        fs = v.done_t - v.nwords;
        e  = '0;
        e.busy = (t <= v.done_t);
        e.done = (t == v.done_t);
        if (t >= 1 && t <= 3) begin
            e.dq_oe  = 1'b1;
            e.dq_out = (t == 1) ? v.ca[47:32] : (t == 2) ? v.ca[31:16] : v.ca[15:0];
        end else if (!rd && !rg && t >= 4 && t < fs) begin
            if (t == fs - 1) begin
                e.rwds_oe  = 1'b1;
                e.rwds_out = 2'b11;
            end
        end else if (t >= fs && t < v.done_t) begin
            j         = t - fs;
            e.dq_oe   = 1'b1;
            e.rwds_oe = !rg;
            if (j == v.gap) begin
                e.dq_out   = 16'h0000;
                e.rwds_out = rg ? 2'b00 : 2'b11;
            end else begin
                e.dq_out   = data_of(v, j);
                e.rwds_out = rg ? 2'b00 : ~strb_of(v, j);
            end
        end
        e.wr_ready  = (v.nwords > 0) && (t >= fs - 1) && (t < v.done_t - 1);
        e.underflow = (v.gap >= 0) && (t >= fs + v.gap);
        return e;
    endfunction

    function automatic obs_t sample();
        return {wr.wr_ready, dq_oe, dq_out, rwds_oe, rwds_out, busy, done, underflow};
    endfunction

    task automatic check_obs(input string tag, input int id, input int t, input obs_t e);
        obs_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s vec%0d t=%0d: got rdy=%b oe=%b dq=%h rwoe=%b rw=%b busy=%b done=%b uf=%b, expected rdy=%b oe=%b dq=%h rwoe=%b rw=%b busy=%b done=%b uf=%b",
                     tag, id, t, a.wr_ready, a.dq_oe, a.dq_out, a.rwds_oe, a.rwds_out, a.busy, a.done, a.underflow,
                     e.wr_ready, e.dq_oe, e.dq_out, e.rwds_oe, e.rwds_out, e.busy, e.done, e.underflow);
        end
    endtask

    // Drives one transfer cycle by cycle; also pokes tx_start in CA and DONE
    // and scrambles tx_ca/latency/len after t=0 to confirm they are ignored.
    task automatic run_txn(input vec_t v, input int max_t);
        int   fs, s;
        obs_t e;
        fs = v.done_t - v.nwords;
        for (int t = 0; t <= v.done_t && t < max_t; t++) begin
            tx_start   = (t == 0) || (t == 2) || (t == v.done_t);
            tx_ca      = (t == 0) ? v.ca : ~v.ca;
            tx_latency = (t == 0) ? LAT_W'(v.lat) : LAT_W'(v.lat + 5);
            tx_len     = (t == 0) ? LEN_W'(v.len) : ~LEN_W'(v.len);
            s = t + 1 - fs;
            if (v.nwords > 0 && s >= 0 && s < v.nwords) begin
                wr.wr_valid = (s != v.gap);
                wr.wr_data  = data_of(v, s);
                wr.wr_strb  = strb_of(v, s);
            end else begin
                wr.wr_valid = 1'b1;
                wr.wr_data  = 16'hDEAD;
                wr.wr_strb  = 2'b00;
            end
            sb.push_back(expect_at(v, t + 1));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_obs("cycle", v.id, t + 1, e);
        end
        tx_start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 48'h2000_1234_0000, 6, 3,   16'h1111, -1,  -1, 2'b11, 4,   14};
        vecs[1] = '{2, 48'h2000_1234_0008, 6, 3,   16'h2222, -1,   1, 2'b01, 4,   14};
        vecs[2] = '{3, 48'h4000_0000_0001, 6, 5,   16'h8F1F, -1,  -1, 2'b11, 1,   5};
        vecs[3] = '{4, 48'h0000_0040_0002, 3, 3,   16'hA5A5,  2,  -1, 2'b11, 4,   11};
        vecs[4] = '{5, 48'h1000_0000_0020, 0, 2,   16'h0F0F, -1,   0, 2'b10, 3,   7};
        vecs[5] = '{6, 48'h8000_0000_0010, 6, 3,   16'h0000, -1,  -1, 2'b11, 0,   4};
        vecs[6] = '{7, 48'h0ABC_DEF0_1234, 1, 0,   16'h5A5A, -1,  -1, 2'b11, 1,   6};
        vecs[7] = '{8, 48'h0000_0000_0100, 2, 255, 16'h1357, 200,  7, 2'b00, 256, 262};
        vecs[8] = '{9, 48'h4000_0000_0003, 0, 0,   16'h2468,  0,  -1, 2'b11, 1,   5};

        arstn       = 1'b0;
        tx_start    = 1'b0;
        tx_ca       = '0;
        tx_latency  = '0;
        tx_len      = '0;
        wr.wr_valid = 1'b0;
        wr.wr_data  = '0;
        wr.wr_strb  = '0;
        #12;
        check_obs("reset", 0, 0, '0);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_txn(vecs[i], 1000);

        // Reset asserted between edges in the middle of the data phase.
        run_txn(vecs[0], 12);
        #2;
        arstn = 1'b0;
        #1;
        check_obs("async_reset", 1, -1, '0);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        check_obs("post_reset_idle", 1, -1, '0);
        run_txn(vecs[1], 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
